// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter: shares one single-port frame-buffer SRAM between the
// display prefetch stream and two drawing requesters, with double buffering.
// Optional macro SRAM_ARB_AUTOCLEAR_EN adds a back-buffer clear engine that
// runs after every swap.
module sram_frame_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              front_buf,
    input  logic              disp_ready,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              underrun,
    input  logic              rq0_req,
    input  logic              rq0_we,
    input  logic [ADDR_W-2:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_gnt,
    input  logic              rq1_req,
    input  logic              rq1_we,
    input  logic [ADDR_W-2:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_gnt,
    output logic              rq_rvalid,
    output logic              rq_rid,
    output logic [DATA_W-1:0] rq_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef SRAM_ARB_AUTOCLEAR_EN
    ,
    input  logic [DATA_W-1:0] clear_data,
    output logic              clear_busy
`endif
);
    localparam int PIX = H_RES * V_RES;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int OW  = AW + 3;

    // Read-return tag: which source issued it and, for display, which frame epoch.
    typedef struct packed {
        logic vld;
        logic disp;
        logic rid;
        logic ep;
    } tag_t;

    tag_t              tag_q [READ_LAT+1];
    tag_t              tag_d [READ_LAT+1];
    tag_t              tag_new, ret;
    logic              front_q, front_d, pend_q, pend_d, swap_done_q, swap_done_d;
    logic              epoch_q, epoch_d, rr_q, rr_d, underrun_q, underrun_d;
    logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d, pop_cnt_q, pop_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d, mem_oe_q, mem_oe_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [2:0]        inflight;
    logic [OW-1:0]     occ;
    logic              disp_elig, disp_urg, g_disp, g_clr, clr_act, rq_block, push, pop;

    // Display reads still owed to the FIFO in this epoch (space already reserved).
    always_comb begin
        inflight = '0;
        for (int k = 0; k <= READ_LAT; k++)
            if (tag_q[k].vld && tag_q[k].disp && tag_q[k].ep == epoch_q)
                inflight = inflight + 3'd1;
        occ = OW'(cnt_q) + OW'(inflight);
    end

`ifdef SRAM_ARB_AUTOCLEAR_EN
    logic              clear_busy_q, clear_busy_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    assign clr_act    = clear_busy_q;
    assign rq_block   = clear_busy_q;
    assign clear_busy = clear_busy_q;

    // Clear engine: (re)starts on each swap, walks the whole new back half.
    always_comb begin
        clear_busy_d = clear_busy_q;
        clr_ptr_d    = clr_ptr_q;
        if (g_clr) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == ADDR_W'(PIX - 1)) clear_busy_d = 1'b0;
        end
        if (swap_done_q) begin
            clear_busy_d = 1'b1;
            clr_ptr_d    = '0;
        end
    end

    // Clear engine state.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            clear_busy_q <= 1'b0;
            clr_ptr_q    <= '0;
        end else begin
            clear_busy_q <= clear_busy_d;
            clr_ptr_q    <= clr_ptr_d;
        end
`else
    assign clr_act  = 1'b0;
    assign rq_block = 1'b0;
`endif

    // Arbitration: urgent display > clear/requesters (round robin) > relaxed display.
    // No display fetch in a frame_start cycle: it would belong to the dying frame.
    always_comb begin
        disp_elig = !frame_start && fetch_ptr_q < ADDR_W'(PIX) && occ < OW'(FIFO_DEPTH);
        disp_urg  = disp_elig && occ < OW'(FIFO_DEPTH / 2);
        g_disp    = 1'b0;
        g_clr     = 1'b0;
        rq0_gnt   = 1'b0;
        rq1_gnt   = 1'b0;
        rr_d      = rr_q;
        if (disp_urg) g_disp = 1'b1;
        else if (clr_act) g_clr = 1'b1;
        else if (!rq_block && (rq0_req || rq1_req)) begin
            if (rq0_req && (!rr_q || !rq1_req)) begin
                rq0_gnt = 1'b1;
                rr_d    = 1'b1;
            end else begin
                rq1_gnt = 1'b1;
                rr_d    = 1'b0;
            end
        end else if (disp_elig) g_disp = 1'b1;
    end

    // Next SRAM command and the tag that will follow it down the read pipe.
    always_comb begin
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_oe_d    = 1'b0;
        mem_wdata_d = '0;
        tag_new     = '0;
        if (g_disp) begin
            mem_addr_d = {front_q, fetch_ptr_q[ADDR_W-2:0]};
            mem_oe_d   = 1'b1;
            tag_new    = '{vld: 1'b1, disp: 1'b1, rid: 1'b0, ep: epoch_q};
        end else if (rq0_gnt) begin
            mem_addr_d  = {~front_q, rq0_addr};
            mem_we_d    = rq0_we;
            mem_oe_d    = ~rq0_we;
            mem_wdata_d = rq0_wdata;
            tag_new     = '{vld: ~rq0_we, disp: 1'b0, rid: 1'b0, ep: epoch_q};
        end else if (rq1_gnt) begin
            mem_addr_d  = {~front_q, rq1_addr};
            mem_we_d    = rq1_we;
            mem_oe_d    = ~rq1_we;
            mem_wdata_d = rq1_wdata;
            tag_new     = '{vld: ~rq1_we, disp: 1'b0, rid: 1'b1, ep: epoch_q};
        end
`ifdef SRAM_ARB_AUTOCLEAR_EN
        else if (g_clr) begin
            mem_addr_d  = {~front_q, clr_ptr_q[ADDR_W-2:0]};
            mem_we_d    = 1'b1;
            mem_wdata_d = clear_data;
        end
`endif
        tag_d[0] = tag_new;
        for (int k = 1; k <= READ_LAT; k++) tag_d[k] = tag_q[k-1];
    end

    assign ret        = tag_q[READ_LAT];
    assign push       = ret.vld && ret.disp && ret.ep == epoch_q && !frame_start;
    assign disp_valid = cnt_q != '0;
    assign pop        = disp_ready && disp_valid && !frame_start;
    assign disp_data  = disp_valid ? fifo_mem_q[rptr_q] : '0;
    assign rq_rvalid  = ret.vld && !ret.disp;
    assign rq_rid     = rq_rvalid && ret.rid;
    assign rq_rdata   = rq_rvalid ? mem_rdata : '0;

    // Frame, FIFO pointer, swap and underrun bookkeeping.
    always_comb begin
        epoch_d     = epoch_q ^ frame_start;
        fetch_ptr_d = g_disp ? fetch_ptr_q + 1'b1 : fetch_ptr_q;
        pop_cnt_d   = pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
        wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        underrun_d  = underrun_q || (disp_ready && !disp_valid && pop_cnt_q < ADDR_W'(PIX));
        pend_d      = pend_q || swap_req;
        front_d     = front_q;
        swap_done_d = 1'b0;
        if (frame_start) begin
            fetch_ptr_d = '0;
            pop_cnt_d   = '0;
            wptr_d      = '0;
            rptr_d      = '0;
            cnt_d       = '0;
            if (pend_q || swap_req) begin
                front_d     = ~front_q;
                pend_d      = 1'b0;
                swap_done_d = 1'b1;
            end
        end
    end

    // State and registered SRAM command.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            front_q <= 1'b0; pend_q <= 1'b0; swap_done_q <= 1'b0; epoch_q <= 1'b0;
            rr_q <= 1'b0; underrun_q <= 1'b0; fetch_ptr_q <= '0; pop_cnt_q <= '0;
            wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
            mem_addr_q <= '0; mem_we_q <= 1'b0; mem_oe_q <= 1'b0; mem_wdata_q <= '0;
            for (int k = 0; k <= READ_LAT; k++) tag_q[k] <= '0;
        end else begin
            front_q <= front_d; pend_q <= pend_d; swap_done_q <= swap_done_d; epoch_q <= epoch_d;
            rr_q <= rr_d; underrun_q <= underrun_d; fetch_ptr_q <= fetch_ptr_d; pop_cnt_q <= pop_cnt_d;
            wptr_q <= wptr_d; rptr_q <= rptr_d; cnt_q <= cnt_d;
            mem_addr_q <= mem_addr_d; mem_we_q <= mem_we_d; mem_oe_q <= mem_oe_d; mem_wdata_q <= mem_wdata_d;
            for (int k = 0; k <= READ_LAT; k++) tag_q[k] <= tag_d[k];
        end

    // FIFO storage; space is reserved at issue so a push never overwrites.
    always_ff @(posedge clk)
        if (push) fifo_mem_q[wptr_q] <= mem_rdata;

    assign swap_done = swap_done_q;
    assign front_buf = front_q;
    assign underrun  = underrun_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Directed bench for sram_frame_arbiter with a small SRAM model (8x2 frame).
module tb_sram_frame_arbiter;
    localparam int AW = 8, DW = 16, RL = 2;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          frame_start = 0, swap_req = 0, disp_ready = 0;
    logic          rq0_req = 0, rq0_we = 0, rq1_req = 0, rq1_we = 0;
    logic [AW-2:0] rq0_addr = '0, rq1_addr = '0;
    logic [DW-1:0] rq0_wdata = '0, rq1_wdata = '0;
    logic          swap_done, front_buf, disp_valid, underrun, rq0_gnt, rq1_gnt;
    logic          rq_rvalid, rq_rid, mem_we, mem_oe;
    logic [DW-1:0] disp_data, rq_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int            checks = 0, failures = 0, npix = 0;
    logic [DW-1:0] pix [16];
    logic [DW-1:0] sram [256];
    logic [DW-1:0] rd_pipe [RL];
    logic          clash = 1'b0;

    sram_frame_arbiter #(.ADDR_W(AW), .DATA_W(DW), .H_RES(8), .V_RES(2),
                         .READ_LAT(RL), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .swap_req(swap_req),
        .swap_done(swap_done), .front_buf(front_buf), .disp_ready(disp_ready),
        .disp_valid(disp_valid), .disp_data(disp_data), .underrun(underrun),
        .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_gnt(rq0_gnt), .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_gnt(rq1_gnt), .rq_rvalid(rq_rvalid), .rq_rid(rq_rid),
        .rq_rdata(rq_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

    always #5 clk = ~clk;

    // SRAM model: front half holds its address, back half 0x1000+addr, back[5]=0xABCD.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int a = 0; a < 256; a++)
                sram[a] <= (a < 128) ? 16'(a) : (a == 133) ? 16'hABCD : 16'(32'h1000 + a - 128);
            for (int k = 0; k < RL; k++) rd_pipe[k] <= '0;
        end else begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            rd_pipe[0] <= mem_oe ? sram[mem_addr] : 16'h0;
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
            if (mem_we && mem_oe) clash <= 1'b1;
        end
    end
    assign mem_rdata = rd_pipe[RL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pop with disp_ready held for a bounded number of cycles, recording up to 16 pixels.
    task automatic collect();
        npix = 0;
        disp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (disp_valid && npix < 16) begin
                pix[npix] = disp_data;
                npix++;
            end
            nxt();
        end
    endtask

    initial begin
        // Reset state
        nxt(3);
        chk("rst_front", 32'(front_buf), 0);
        chk("rst_swap_done", 32'(swap_done), 0);
        chk("rst_disp_valid", 32'(disp_valid), 0);
        chk("rst_disp_data", 32'(disp_data), 0);
        chk("rst_mem_cmd", {30'd0, mem_we, mem_oe}, 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_rvalid", 32'(rq_rvalid), 0);
        reset_n = 1'b1;
        nxt(5);

        // Frame from front half 0: pixels 0..15 in order, no underrun
        frame_start = 1; nxt(); frame_start = 0;
        nxt(20);
        chk("prefill_valid", 32'(disp_valid), 1);
        collect();
        chk("f0_npix", 32'(npix), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("f0_pix%0d", i), 32'(pix[i]), 32'(i));
        chk("f0_underrun", 32'(underrun), 0);
        chk("f0_valid_after", 32'(disp_valid), 0);
        disp_ready = 0;

        // Both requesters write back-to-back: grants alternate, back-half addresses
        rq0_req = 1; rq0_we = 1; rq0_addr = 7'd10; rq0_wdata = 16'h1111;
        rq1_req = 1; rq1_we = 1; rq1_addr = 7'd11; rq1_wdata = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_gnt0_%0d", i), 32'(rq0_gnt), 32'(i % 2 == 0));
            chk($sformatf("rr_gnt1_%0d", i), 32'(rq1_gnt), 32'(i % 2 == 1));
            nxt();
            chk($sformatf("rr_addr_%0d", i), 32'(mem_addr), (i % 2 == 0) ? 32'h8A : 32'h8B);
            chk($sformatf("rr_wdata_%0d", i), 32'(mem_wdata), (i % 2 == 0) ? 32'h1111 : 32'h2222);
            chk($sformatf("rr_cmd_%0d", i), {30'd0, mem_we, mem_oe}, 32'b10);
        end
        rq0_req = 0; rq1_req = 0;
        nxt(2);

        // rq1 read of back addr 5: data 3 cycles after grant
        rq1_req = 1; rq1_we = 0; rq1_addr = 7'd5;
        #1;
        chk("rd_gnt", 32'(rq1_gnt), 1);
        nxt(); rq1_req = 0;
        chk("rd_cmd", {22'd0, mem_addr, mem_we, mem_oe}, {22'd0, 8'h85, 2'b01});
        chk("rd_early1", 32'(rq_rvalid), 0);
        nxt();
        chk("rd_early2", 32'(rq_rvalid), 0);
        nxt();
        chk("rd_resp", {15'd0, rq_rvalid, rq_rid, rq_rdata}, {15'd0, 1'b1, 1'b1, 16'hABCD});
        nxt();
        chk("rd_done", 32'(rq_rvalid), 0);

        // Swap requested 10 cycles before frame_start
        swap_req = 1; nxt(); swap_req = 0;
        nxt(9);
        chk("sw_pending_front", 32'(front_buf), 0);
        chk("sw_pending_done", 32'(swap_done), 0);
        frame_start = 1; nxt(); frame_start = 0;
        chk("sw_front", 32'(front_buf), 1);
        chk("sw_done_pulse", 32'(swap_done), 1);
        nxt();
        chk("sw_done_clear", 32'(swap_done), 0);
        nxt(20);
        collect();
        disp_ready = 0;
        chk("f1_npix", 32'(npix), 16);
        chk("f1_pix0", 32'(pix[0]), 32'h1000);
        chk("f1_pix5", 32'(pix[5]), 32'hABCD);
        chk("f1_pix10", 32'(pix[10]), 32'h1111);
        chk("f1_pix11", 32'(pix[11]), 32'h2222);
        chk("f1_pix15", 32'(pix[15]), 32'h100F);

        // Early vsync with reads in flight, swap_req coincident with frame_start
        frame_start = 1; nxt(); frame_start = 0;
        nxt(3);
        frame_start = 1; swap_req = 1; nxt(); frame_start = 0; swap_req = 0;
        chk("mid_front", 32'(front_buf), 0);
        chk("mid_done", 32'(swap_done), 1);
        nxt(20);
        collect();
        disp_ready = 0;
        chk("mid_npix", 32'(npix), 16);
        chk("mid_pix0", 32'(pix[0]), 0);
        chk("mid_pix1", 32'(pix[1]), 1);
        chk("mid_pix15", 32'(pix[15]), 15);
        chk("mid_underrun", 32'(underrun), 0);

        // Requesters flood while display pops every cycle: urgent display keeps up
        rq0_req = 1; rq0_we = 1; rq0_addr = 7'd20;
        rq1_req = 1; rq1_we = 1; rq1_addr = 7'd21;
        frame_start = 1; nxt(); frame_start = 0;
        nxt(12);
        collect();
        disp_ready = 0; rq0_req = 0; rq1_req = 0;
        chk("fl_npix", 32'(npix), 16);
        chk("fl_pix0", 32'(pix[0]), 0);
        chk("fl_pix15", 32'(pix[15]), 15);
        chk("fl_underrun", 32'(underrun), 0);
        chk("fl_no_clash", 32'(clash), 0);

        // Pop on empty right after frame_start: underrun sets and sticks
        frame_start = 1; nxt(); frame_start = 0;
        disp_ready = 1;
        #1;
        chk("ur_valid", 32'(disp_valid), 0);
        chk("ur_data", 32'(disp_data), 0);
        nxt(); disp_ready = 0;
        chk("ur_set", 32'(underrun), 1);
        nxt(30);
        chk("ur_sticky", 32'(underrun), 1);
        reset_n = 0; #1;
        chk("ur_reset", 32'(underrun), 0);
        chk("ur_reset_front", 32'(front_buf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_frame_arbiter.md
Name: sram_frame_arbiter

Overview:
- Shares one single-port frame-buffer SRAM (behind sram_controller) between three agents: the VGA display prefetch stream and two drawing requesters (sprite drawer, background painter).
- Manages double buffering. Display reads the front half; requesters access the back half.
- Swaps halves only on a frame boundary.
- Sits between the game-logic drawers, vga_color_extend, and the SRAM physical controller.

Parameters:
- ADDR_W, 20, SRAM word address width. The MSB selects the buffer half.
- DATA_W, 16, pixel word width.
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- READ_LAT, 2, cycles from mem_addr/mem_oe presented to mem_rdata valid (1..4).
- FIFO_DEPTH, 16, display pixel FIFO entries (power of 2, at least 4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of a frame (vertical sync edge)
- swap_req  in  1  pulse: swap buffers at next frame_start
- swap_done  out  1  one-cycle pulse when the swap takes effect
- front_buf  out  1  current display half
- disp_ready  in  1  display pops one pixel
- disp_valid  out  1  disp_data holds the FIFO head
- disp_data  out  DATA_W  next display pixel (0 when empty)
- underrun  out  1  sticky: pop attempted on an empty FIFO mid-frame
- rqN_req  in  1  request (N=0,1)
- rqN_we  in  1  1 = write, 0 = read
- rqN_addr  in  ADDR_W-1  back-buffer word address
- rqN_wdata  in  DATA_W  write data
- rqN_gnt  out  1  request accepted this cycle
- rq_rvalid  out  1  read data valid
- rq_rid  out  1  requester index for rq_rdata
- rq_rdata  out  DATA_W  read data
- mem_addr  out  ADDR_W  SRAM address
- mem_we  out  1  write strobe
- mem_oe  out  1  read strobe
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (async, reset_n=0): all outputs 0, front_buf=0, FIFO empty, fetch pointer 0, swap pending cleared, round-robin pointer favours rq0.
- Throughput: at most one SRAM access per cycle. mem_we and mem_oe are never high together. Both are 0 when idle.
- Handshake: requester holds req/we/addr/wdata stable until gnt. Transfer occurs when req&gnt. gnt is combinational in the same cycle.
- Access pipeline: arbitration in cycle t. mem_* are registered and valid in t+1. For reads, data returns at t+1+READ_LAT.
  - Requester reads: rq_rvalid/rq_rid/rq_rdata at t+1+READ_LAT. A shift-register tag pipeline carries the source.
  - Display reads: data enters the FIFO at t+1+READ_LAT.
- Address map: display address = {front_buf, fetch_ptr}. Requester address = {~front_buf, rqN_addr}.
- Display fetch eligibility: fetch_ptr < H_RES*V_RES and (fifo_count + inflight) < FIFO_DEPTH.
  - Urgent when fifo_count + inflight < FIFO_DEPTH/2.
- Priority: urgent display > requesters (round robin between rq0/rq1; pointer flips to the other after each grant) > non-urgent display.
- FIFO: pop on disp_ready&disp_valid. Push and pop in the same cycle leave the count unchanged. It cannot overflow, because the inflight reservation guarantees space.
- Frame end: after fetch_ptr reaches H_RES*V_RES, no display fetches occur. A pop on empty FIFO after the last pixel is delivered does not set underrun.
- underrun: set on disp_ready with FIFO empty while the frame is incomplete. disp_data=0 in that case. Cleared only by reset.
- frame_start:
  - fetch_ptr <= 0 and FIFO flushed.
  - An epoch bit toggles; returning display reads tagged with the old epoch are discarded.
  - Requester reads in flight complete normally.
- Swap:
  - swap_req sets pending.
  - At frame_start with pending (including swap_req in the same cycle), front_buf toggles, pending clears, and swap_done pulses in the next cycle.
  - swap_req while already pending has no extra effect.
- Mid-frame frame_start (early vsync): same flush and restart as above. The swap rule still applies.

Optional Feature:
- Macro: SRAM_ARB_AUTOCLEAR_EN.
- Defined:
  - Adds ports clear_data (in, DATA_W) and clear_busy (out, 1).
  - On every swap, a clear engine writes clear_data to every address 0..H_RES*V_RES-1 of the new back half.
  - Clear writes take the requester slot; rq0_gnt and rq1_gnt are held 0 while clear_busy.
  - clear_busy rises the cycle after swap_done and falls the cycle after the last clear write.
  - A new swap during a clear restarts the clear on the new back half.
- Undefined: ports absent, no clearing, requesters never blocked.

Test Plan:
- H_RES=8, V_RES=2, preload front half with addr-as-data; frame_start, disp_ready held 1 after 20 cycles -> 16 pixels 0..15 in order, underrun=0, disp_valid=0 afterward.
- rq0 and rq1 both write continuously with display FIFO full -> grants alternate 0,1,0,1; mem_addr MSB = ~front_buf; mem_we never coincides with mem_oe.
- rq1 read addr 5 (back half holds 0xABCD), READ_LAT=2 -> rq_rvalid with rq_rid=1, rq_rdata=0xABCD exactly 3 cycles after gnt.
- swap_req, then frame_start 10 cycles later -> front_buf toggles; swap_done pulses once; next frame's display reads hit the other half. swap_req coincident with frame_start -> same result.
- Disable disp fetch by flooding requesters? no, urgent wins: flood both requesters, pop every cycle -> underrun stays 0; force READ_LAT=4, FIFO_DEPTH=4, pop every cycle -> underrun set and stays set until reset_n.
- frame_start mid-frame with display reads in flight -> stale data never appears; first pixel after restart is front-half address 0.
